// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: combinational stall/flush steering,
// post-flush recovery FSM, EX-stall watchdog and saturating statistics.
module pipe_ctrl #(
  parameter int MAX_EX_STALL = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int EW_W = $clog2(MAX_EX_STALL) + 1;
  localparam logic [EW_W-1:0] EX_LIMIT = EW_W'(MAX_EX_STALL - 1);

  localparam logic [5:0] HOLD_EX = 6'b001111;
  localparam logic [5:0] HOLD_ID = 6'b000111;

  typedef enum logic [1:0] {RUN, EX_WAIT, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [EW_W-1:0] ex_wait;
  logic            ex_count;

  assign ex_count = stallreq_ex & ~flush_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      ex_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      ex_busy <= (state_nxt == EX_WAIT);
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = '0;
    flush     = 1'b0;
    new_pc    = '0;

    if (flush_req) begin
      state_nxt = FLUSH;
    end else begin
      unique case (state)
        RUN:     if (stallreq_ex) state_nxt = EX_WAIT;
        EX_WAIT: if (!stallreq_ex) state_nxt = RUN;
        FLUSH:   state_nxt = stallreq_ex ? EX_WAIT : RUN;
        default: state_nxt = RUN;
      endcase
    end

    // In FLUSH the ID slot holds a killed instruction, so its hazard is moot.
    if (!rst) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (stallreq_ex) begin
        stall = HOLD_EX;
      end else if (stallreq_id && state != FLUSH) begin
        stall = HOLD_ID;
      end
    end
  end

  // Watchdog only flags; it never overrides the stall request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wait     <= '0;
      timeout_err <= 1'b0;
    end else if (ex_count) begin
      if (ex_wait == EX_LIMIT) timeout_err <= 1'b1;
      if (ex_wait != '1) ex_wait <= ex_wait + 1'b1;
    end else begin
      ex_wait <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != '0 && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
